// File: rtl/frame_rx_buf.sv
// Frame receive buffer: hunts for a SYNC byte, stores N = row_depth*column_depth
// pixels, verifies a modulo-2^D_BITS additive checksum, then drains the pixels
// downstream with a valid/ready handshake.
module frame_rx_buf #(
  parameter int unsigned       row_depth    = 7,
  parameter int unsigned       column_depth = 7,
  parameter int unsigned       D_BITS       = 8,
  parameter logic [D_BITS-1:0] SYNC         = 8'hA5,
  parameter int unsigned       TIMEOUT      = 100000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_drdy,
  input  logic              i_rdy,
  output logic [D_BITS-1:0] o_data,
  output logic              o_dvalid,
  output logic              o_frame_ok,
  output logic              o_err,
  output logic              o_ovf,
  output logic              o_busy,
  output logic [31:0]       tot
);

  localparam int unsigned N  = row_depth * column_depth;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StChk, StDrain} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       wr_idx_q, wr_idx_d;
  logic [IW-1:0]       rd_idx_q, rd_idx_d;
  logic [D_BITS-1:0]   sum_q, sum_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [D_BITS-1:0]   data_q, data_d;
  logic                dvalid_q, dvalid_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                mem_we;
  logic [IW-1:0]       rd_next;
  logic [D_BITS-1:0]   mem_q [N];

  assign rd_next = rd_idx_q + 1'b1;

  // Next-state, datapath and flag-pulse decode for all four states.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dvalid_d = dvalid_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_drdy && i_data == SYNC) begin
          state_d  = StLoad;
          wr_idx_d = '0;
          sum_d    = '0;
          cnt_d    = '0;
        end
      end
      StLoad, StChk: begin
        if (i_drdy) begin
          cnt_d = '0;
          if (state_q == StLoad) begin
            // SYNC-valued bytes here are ordinary payload.
            mem_we = 1'b1;
            sum_d  = sum_q + i_data;
            if (wr_idx_q == LastIdx) state_d = StChk;
            else wr_idx_d = wr_idx_q + 1'b1;
          end else if (i_data == sum_q) begin
            state_d  = StDrain;
            ok_d     = 1'b1;
            rd_idx_d = '0;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d >= 32'(TIMEOUT)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        ovf_d = i_drdy;
        if (!dvalid_q) begin
          // First drain cycle only presents pixel 0.
          dvalid_d = 1'b1;
          data_d   = mem_q[rd_idx_q];
        end else if (i_rdy) begin
          if (rd_idx_q == LastIdx) begin
            state_d  = StIdle;
            dvalid_d = 1'b0;
          end else begin
            rd_idx_d = rd_next;
            data_d   = mem_q[rd_next];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // Pixel storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_idx_q] <= i_data;
  end

  assign o_data     = data_q;
  assign o_dvalid   = dvalid_q;
  assign o_frame_ok = ok_q;
  assign o_err      = err_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = (state_q != StIdle);
  assign tot        = 32'(N);

endmodule

// File: tb/tb_frame_rx_buf.sv
// Directed bench for frame_rx_buf with a 2x2 frame and TIMEOUT of 20.
module tb_frame_rx_buf;

  logic       i_clk = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_drdy;
  logic       i_rdy;
  logic [7:0] o_data;
  logic       o_dvalid;
  logic       o_frame_ok;
  logic       o_err;
  logic       o_ovf;
  logic       o_busy;
  logic [31:0] tot;

  int checks = 0;
  int errors = 0;

  frame_rx_buf #(
    .row_depth   (2),
    .column_depth(2),
    .D_BITS      (8),
    .SYNC        (8'hA5),
    .TIMEOUT     (20)
  ) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .i_data    (i_data),
    .i_drdy    (i_drdy),
    .i_rdy     (i_rdy),
    .o_data    (o_data),
    .o_dvalid  (o_dvalid),
    .o_frame_ok(o_frame_ok),
    .o_err     (o_err),
    .o_ovf     (o_ovf),
    .o_busy    (o_busy),
    .tot       (tot)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_data = b;
    i_drdy = 1'b1;
    tick();
    i_drdy = 1'b0;
  endtask

  // Sends A5,01,02,03,04,0A with i_rdy high and checks the full drain.
  task automatic good_frame(input string tag);
    i_rdy = 1'b1;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk({tag, "_busy_chk"}, {31'd0, o_busy}, 32'd1);
    send(8'h0A);
    chk({tag, "_ok"}, {31'd0, o_frame_ok}, 32'd1);
    chk({tag, "_dv0"}, {31'd0, o_dvalid}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk({tag, "_dv"}, {31'd0, o_dvalid}, 32'd1);
      chk({tag, "_data"}, {24'd0, o_data}, i);
      chk({tag, "_ok_pulse"}, {31'd0, o_frame_ok}, 32'd0);
    end
    tick();
    chk({tag, "_dv_end"}, {31'd0, o_dvalid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int err_at;
    int err_cnt;
    reset  = 1'b1;
    i_data = 8'h00;
    i_drdy = 1'b0;
    i_rdy  = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_dv", {31'd0, o_dvalid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_flags", {29'd0, o_frame_ok, o_err, o_ovf}, 32'd0);
    chk("tot", tot, 32'd4);
    reset = 1'b0;
    tick();

    // Good frame, continuous ready.
    good_frame("good");

    // Bad checksum.
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0B);
    chk("bad_err", {31'd0, o_err}, 32'd1);
    chk("bad_ok", {31'd0, o_frame_ok}, 32'd0);
    chk("bad_busy", {31'd0, o_busy}, 32'd0);
    err_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_dvalid || o_err) err_cnt++;
    end
    chk("bad_quiet", err_cnt, 32'd0);

    // Stray byte ignored, SYNC values as payload.
    send(8'h33);
    chk("stray_idle", {31'd0, o_busy}, 32'd0);
    send(8'hA5);
    chk("sync_busy", {31'd0, o_busy}, 32'd1);
    send(8'hA5); send(8'hFF); send(8'h01); send(8'h00);
    send(8'hA5);
    chk("sp_ok", {31'd0, o_frame_ok}, 32'd1);
    tick(); chk("sp_d0", {23'd0, o_dvalid, o_data}, 32'h1A5);
    tick(); chk("sp_d1", {23'd0, o_dvalid, o_data}, 32'h1FF);
    tick(); chk("sp_d2", {23'd0, o_dvalid, o_data}, 32'h101);
    tick(); chk("sp_d3", {23'd0, o_dvalid, o_data}, 32'h100);
    tick(); chk("sp_end", {30'd0, o_dvalid, o_busy}, 32'd0);

    // Backpressure and overflow during drain.
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    i_rdy = 1'b0;
    send(8'h0A);
    chk("bp_ok", {31'd0, o_frame_ok}, 32'd1);
    tick(); chk("bp_d0", {23'd0, o_dvalid, o_data}, 32'h101);
    send(8'h55);
    chk("bp_hold0", {23'd0, o_dvalid, o_data}, 32'h101);
    chk("bp_ovf", {31'd0, o_ovf}, 32'd1);
    tick();
    chk("bp_ovf_pulse", {31'd0, o_ovf}, 32'd0);
    chk("bp_hold1", {23'd0, o_dvalid, o_data}, 32'h101);
    i_rdy = 1'b1; tick(); chk("bp_d1", {23'd0, o_dvalid, o_data}, 32'h102);
    i_rdy = 1'b0; tick(); chk("bp_hold2", {23'd0, o_dvalid, o_data}, 32'h102);
    i_rdy = 1'b1; tick(); chk("bp_d2", {23'd0, o_dvalid, o_data}, 32'h103);
    tick(); chk("bp_d3", {23'd0, o_dvalid, o_data}, 32'h104);
    tick(); chk("bp_end", {30'd0, o_dvalid, o_busy}, 32'd0);

    // Timeout after 20 idle cycles.
    send(8'hA5); send(8'h01);
    err_at  = 0;
    err_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (o_err) begin
        err_cnt++;
        if (err_at == 0) err_at = k;
      end
    end
    chk("to_cycle", err_at, 32'd20);
    chk("to_pulses", err_cnt, 32'd1);
    chk("to_idle", {31'd0, o_busy}, 32'd0);
    good_frame("after_to");

    // Asynchronous reset mid-frame.
    send(8'hA5); send(8'h01); send(8'h02);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_data", {24'd0, o_data}, 32'd0);
    chk("arst_tot", tot, 32'd4);
    tick();
    reset = 1'b0;
    tick();
    good_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
